// File: rtl/i2s_stereo_mic_capture_ctrl.sv
// i2s_stereo_mic_capture_ctrl
//
// I2S bus master for a pair of INMP441 microphones that share one SD line.
// The left mic is strapped L/R=0 and the right mic is strapped L/R=1.
// The block generates SCK and WS, runs WARMUP_FRAMES discarded frames after
// every start so the mics can settle, then deserialises one 24-bit sample
// from each slot. Each left/right pair is offered on a valid/ready stream.
// A stop request always lets the frame already on the bus run to its end.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              level request: 1 = capture
//   sck, ws             I2S bit clock and word select (ws=0 left, ws=1 right)
//   sd                  shared I2S serial data from both mics
//   out_left/out_right  24-bit two's-complement sample pair
//   out_valid/out_ready stream handshake for the pair
//   overflow            sticky: a completed pair found the output still full
//   running             1 while in the RUN state
//   drop_count          16-bit saturating count of dropped pairs; this port
//                       exists only when I2S_CAPTURE_DROP_CNT_EN is defined
//
// Optional build macro: I2S_CAPTURE_DROP_CNT_EN

module i2s_stereo_mic_capture_ctrl #(
  parameter int unsigned SCK_HALF      = 8,
  parameter int unsigned WARMUP_FRAMES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                sck,
  output logic                ws,
  input  logic                sd,
  output logic signed [23:0]  out_left,
  output logic signed [23:0]  out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                running
`ifdef I2S_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam int unsigned DATA_W    = 24;
  localparam logic [7:0]  HALF_LAST = 8'(SCK_HALF - 1);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_STOPPING
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                hcnt_q, hcnt_d;
  logic                      phase_q, phase_d;
  logic [5:0]                bit_q, bit_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic                      stop_from_run_q, stop_from_run_d;
  logic signed [DATA_W-1:0]  left_sr_q, left_sr_d;
  logic signed [DATA_W-1:0]  right_sr_q, right_sr_d;
  logic signed [DATA_W-1:0]  out_left_q, out_left_d;
  logic signed [DATA_W-1:0]  out_right_q, out_right_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overflow_q, overflow_d;
`ifdef I2S_CAPTURE_DROP_CNT_EN
  logic [15:0]               drop_cnt_q, drop_cnt_d;
`endif

  logic bus_active;
  logic half_end;
  logic bit_end;
  logic frame_end;
  logic in_left_slot;
  logic in_right_slot;
  logic offer;
  logic load_pair;
  logic drop_pair;
  logic clear_stats;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bit timing: each SCK period is a low half followed by a high half.
  // The bit index advances at the end of the high half, so ws (bit_q[5])
  // only changes together with a falling SCK edge.
  always_comb begin
    bus_active    = (state_q != ST_IDLE);
    half_end      = bus_active && (hcnt_q == HALF_LAST);
    bit_end       = half_end && phase_q;
    frame_end     = bit_end && (bit_q == 6'd63);
    // b=0 and b=32 are the one-bit I2S delay slots.
    in_left_slot  = (bit_q >= 6'd1)  && (bit_q <= 6'd24);
    in_right_slot = (bit_q >= 6'd33) && (bit_q <= 6'd56);

    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (!bus_active) begin
      hcnt_d  = 8'd0;
      phase_d = 1'b0;
      bit_d   = 6'd0;
    end else if (half_end) begin
      hcnt_d  = 8'd0;
      phase_d = ~phase_q;
      if (phase_q) begin
        bit_d = bit_q + 6'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 8'd1;
    end

    // sd is taken on the last clk of the high half, which is the latest
    // point before the mic drives the next bit on the falling edge.
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    if (bit_end && in_left_slot) begin
      left_sr_d = {left_sr_q[DATA_W-2:0], sd};
    end
    if (bit_end && in_right_slot) begin
      right_sr_d = {right_sr_q[DATA_W-2:0], sd};
    end
  end

  // Sequencing. A stop request on the frame's last clk needs no STOPPING
  // pass because the bus is already at a frame boundary.
  always_comb begin
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    stop_from_run_d = stop_from_run_q;
    offer           = 1'b0;
    clear_stats     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d         = ST_WARMUP;
          frame_cnt_d     = 16'd0;
          stop_from_run_d = 1'b0;
          clear_stats     = 1'b1;
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          state_d         = frame_end ? ST_IDLE : ST_STOPPING;
          stop_from_run_d = 1'b0;
        end else if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (frame_cnt_q == WARM_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        offer = frame_end;
        if (!enable) begin
          state_d         = frame_end ? ST_IDLE : ST_STOPPING;
          stop_from_run_d = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (frame_end) begin
          state_d = ST_IDLE;
          offer   = stop_from_run_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output holding register. A pair can load while the previous one is
  // being accepted on the same clk. Otherwise a full output drops the new pair.
  always_comb begin
    load_pair = offer && (!out_valid_q || out_ready);
    drop_pair = offer && !load_pair;

    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    if (load_pair) begin
      out_left_d  = left_sr_q;
      out_right_d = right_sr_q;
    end

    out_valid_d = out_valid_q;
    if (load_pair) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    overflow_d = overflow_q;
    if (clear_stats) begin
      overflow_d = 1'b0;
    end else if (drop_pair) begin
      overflow_d = 1'b1;
    end

`ifdef I2S_CAPTURE_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
    if (clear_stats) begin
      drop_cnt_d = 16'd0;
    end else if (drop_pair) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hcnt_q          <= 8'd0;
      phase_q         <= 1'b0;
      bit_q           <= 6'd0;
      frame_cnt_q     <= 16'd0;
      stop_from_run_q <= 1'b0;
      left_sr_q       <= '0;
      right_sr_q      <= '0;
      out_left_q      <= '0;
      out_right_q     <= '0;
      out_valid_q     <= 1'b0;
      overflow_q      <= 1'b0;
`ifdef I2S_CAPTURE_DROP_CNT_EN
      drop_cnt_q      <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      hcnt_q          <= hcnt_d;
      phase_q         <= phase_d;
      bit_q           <= bit_d;
      frame_cnt_q     <= frame_cnt_d;
      stop_from_run_q <= stop_from_run_d;
      left_sr_q       <= left_sr_d;
      right_sr_q      <= right_sr_d;
      out_left_q      <= out_left_d;
      out_right_q     <= out_right_d;
      out_valid_q     <= out_valid_d;
      overflow_q      <= overflow_d;
`ifdef I2S_CAPTURE_DROP_CNT_EN
      drop_cnt_q      <= drop_cnt_d;
`endif
    end
  end

  assign sck       = phase_q;
  assign ws        = bit_q[5];
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign running   = (state_q == ST_RUN);
`ifdef I2S_CAPTURE_DROP_CNT_EN
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_stereo_mic_capture_ctrl.sv
// Directed bench for i2s_stereo_mic_capture_ctrl with SCK_HALF=8 and
// WARMUP_FRAMES=2. A behavioural pair of I2S mics drives sd from sck and ws.
// The bench covers warm-up, streaming, back-pressure, the clean stop,
// reset in mid-frame and a one-clk enable pulse.

module tb_i2s_stereo_mic_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sck;
  logic        ws;
  logic        sd = 1'b0;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overflow;
  logic        running;
`ifdef I2S_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  logic [23:0] mic_l = 24'h800001;
  logic [23:0] mic_r = 24'h7FFFFE;

  int n_checks = 0;
  int n_fail = 0;
  int v_seen = 0;
  int sck_rises = 0;
  logic sck_prev = 1'b0;

  i2s_stereo_mic_capture_ctrl #(
    .SCK_HALF      (8),
    .WARMUP_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .running    (running)
`ifdef I2S_CAPTURE_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Mic pair model: each mic drives on the falling SCK edge. A ws change
  // starts a slot, the first bit of the slot is the delay bit, and then the
  // MSB follows. Bits outside the 24 data bits are driven 1 so that a
  // capture of the wrong bit positions shows up in the data.
  int          mic_idx = 0;
  logic        mic_ws_prev = 1'b0;
  logic [23:0] mic_word;
  always @(negedge sck or posedge reset) begin
    #1;
    if (reset) begin
      mic_idx     = 0;
      mic_ws_prev = 1'b0;
      sd          = 1'b0;
    end else begin
      if (ws !== mic_ws_prev) mic_idx = 0;
      else mic_idx = mic_idx + 1;
      mic_ws_prev = ws;
      mic_word = ws ? mic_r : mic_l;
      if (mic_idx >= 1 && mic_idx <= 24) sd = mic_word[24 - mic_idx];
      else sd = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out_valid) v_seen++;
      if (sck && !sck_prev) sck_rises++;
      sck_prev = sck;
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  int n;

  initial begin
    // Reset state
    tick(3);
    check_eq("rst_sck", sck, 1'b0);
    check_eq("rst_ws", ws, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_left", out_left, 24'h0);
    check_eq("rst_right", out_right, 24'h0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_running", running, 1'b0);
    reset = 1'b0;
    tick(2);
    check_eq("idle_sck", sck, 1'b0);

    // Start: warm-up of two frames, bus timing
    enable = 1'b1;
    tick(1);
    v_seen = 0;
    sck_rises = 0;
    check_eq("warm_sck0", sck, 1'b0);
    check_eq("warm_running", running, 1'b0);
    tick(8);
    check_eq("sck_high", sck, 1'b1);
    tick(8);
    check_eq("sck_low", sck, 1'b0);
    tick(495);
    check_eq("ws_before_32", ws, 1'b0);
    tick(1);
    check_eq("ws_at_32", ws, 1'b1);
    tick(512);
    check_eq("ws_at_frame2", ws, 1'b0);
    tick(1023);
    check_eq("running_late_warm", running, 1'b0);
    tick(1);
    check_eq("running_run", running, 1'b1);
    check_eq("warm_no_valid", v_seen, 0);
    check_eq("warm_sck_rises", sck_rises, 128);

    // First pair after one RUN frame
    wait_valid(2000, n);
    check_eq("first_valid_lat", n, 1024);
    check_eq("pair1_left", out_left, 24'h800001);
    check_eq("pair1_right", out_right, 24'h7FFFFE);
    tick(1);
    check_eq("pair1_taken", out_valid, 1'b0);
    wait_valid(2000, n);
    check_eq("pair2_lat", n, 1023);
    check_eq("pair2_left", out_left, 24'h800001);
    check_eq("pair2_right", out_right, 24'h7FFFFE);
    tick(1);

    // Back-pressure across three frame ends
    out_ready = 1'b0;
    wait_valid(2000, n);
    check_eq("pair3_lat", n, 1023);
    mic_l = 24'h123456;
    mic_r = 24'hABCDEF;
    tick(1023);
    check_eq("ovf_before_drop", overflow, 1'b0);
    check_eq("held_valid", out_valid, 1'b1);
    tick(1);
    check_eq("ovf_first_drop", overflow, 1'b1);
`ifdef I2S_CAPTURE_DROP_CNT_EN
    check_eq("drop_cnt_1", drop_count, 16'd1);
`endif
    tick(1024);
    check_eq("held_left", out_left, 24'h800001);
    check_eq("held_right", out_right, 24'h7FFFFE);
    check_eq("held_valid2", out_valid, 1'b1);
    check_eq("ovf_sticky", overflow, 1'b1);
`ifdef I2S_CAPTURE_DROP_CNT_EN
    check_eq("drop_cnt_2", drop_count, 16'd2);
`endif
    out_ready = 1'b1;
    tick(1);
    check_eq("valid_release", out_valid, 1'b0);
    check_eq("ovf_still", overflow, 1'b1);
    wait_valid(2000, n);
    check_eq("new_pair_lat", n, 1023);
    check_eq("new_left", out_left, 24'h123456);
    check_eq("new_right", out_right, 24'hABCDEF);

    // Stop requested at b=10 of a RUN frame
    tick(160);
    enable = 1'b0;
    sck_rises = 0;
    tick(1);
    check_eq("stop_running", running, 1'b0);
    wait_valid(2000, n);
    check_eq("stop_pair_lat", n, 863);
    check_eq("stop_sck_rises", sck_rises, 54);
    check_eq("stop_left", out_left, 24'h123456);
    check_eq("stop_right", out_right, 24'hABCDEF);
    check_eq("stop_sck", sck, 1'b0);
    check_eq("stop_ws", ws, 1'b0);
    tick(1);
    check_eq("stop_valid_clr", out_valid, 1'b0);
    sck_rises = 0;
    tick(100);
    check_eq("idle_no_sck", sck_rises, 0);

    // Restart clears the sticky flag and repeats warm-up
    enable = 1'b1;
    tick(1);
    check_eq("restart_ovf_clr", overflow, 1'b0);
`ifdef I2S_CAPTURE_DROP_CNT_EN
    check_eq("restart_drop_clr", drop_count, 16'd0);
`endif
    mic_l = 24'h0F0F0F;
    mic_r = 24'hF0F0F1;
    wait_valid(4000, n);
    check_eq("restart_lat", n, 3072);
    check_eq("restart_left", out_left, 24'h0F0F0F);
    check_eq("restart_right", out_right, 24'hF0F0F1);

    // Reset during b=40 (SCK high, right slot)
    out_ready = 1'b0;
    tick(1024);
    check_eq("pre_rst_ovf", overflow, 1'b1);
    tick(650);
    check_eq("pre_rst_sck", sck, 1'b1);
    check_eq("pre_rst_ws", ws, 1'b1);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_sck", sck, 1'b0);
    check_eq("midrst_ws", ws, 1'b0);
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_ovf", overflow, 1'b0);
    check_eq("midrst_running", running, 1'b0);
    check_eq("midrst_left", out_left, 24'h0);
    out_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    wait_valid(4000, n);
    check_eq("post_rst_lat", n, 3073);
    check_eq("post_rst_left", out_left, 24'h0F0F0F);
    check_eq("post_rst_right", out_right, 24'hF0F0F1);

    // One-clk enable pulse: one frame on the bus, no pair
    enable = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    sck_rises = 0;
    v_seen = 0;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(1);
    check_eq("pulse_running", running, 1'b0);
    tick(1200);
    check_eq("pulse_sck_rises", sck_rises, 64);
    check_eq("pulse_no_valid", v_seen, 0);
    check_eq("pulse_sck_end", sck, 1'b0);
    check_eq("pulse_ws_end", ws, 1'b0);
    check_eq("pulse_running_end", running, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_stereo_mic_capture_ctrl.md
Name: i2s_stereo_mic_capture_ctrl

Overview:
Master-side controller for a shared I2S bus with two INMP441 microphones, one strapped L/R=0 (left) and one strapped L/R=1 (right). It generates SCK and WS, holds both mics through their power-up settling time, and deserialises 24-bit samples from both slots of each frame. It delivers left/right pairs over a valid/ready stream to downstream DSP/display logic. Start/stop is sequenced cleanly so a frame is never truncated on the bus.

Parameters:
SCK_HALF, 8, clk cycles per SCK half-period (50 MHz / 16 = 3.125 MHz SCK); legal range 2..255
WARMUP_FRAMES, 4096, frames discarded after start (4096 x 64 SCK ≈ 84 ms mic settling); legal range 1..65535

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = capture requested
sck  output  1  I2S bit clock to both mics
ws  output  1  I2S word select; 0 = left slot, 1 = right slot
sd  input  1  shared I2S serial data from both mics
out_left  output  24  left sample, two's complement
out_right  output  24  right sample, two's complement
out_valid  output  1  sample pair available
out_ready  input  1  downstream accepts the pair
overflow  output  1  sticky flag: a completed pair was dropped
running  output  1  1 in RUN state

Behaviour:
- Reset values: sck=0, ws=0, out_left=0, out_right=0, out_valid=0, overflow=0, running=0. All internal counters are 0 and the state is IDLE.
- Timing counters: the half-period counter counts 0..SCK_HALF-1. The phase bit toggles on each wrap, and sck = phase.
- Each SCK period is low phase first, then high phase.
- The bit counter b runs 0..63 per frame and advances at the end of each high phase.
- ws = (b >= 32). It therefore changes only at the start of a low phase, which corresponds to the falling edge.
- Sampling: sd is registered on the last clk of each high phase, giving maximum setup after the mic drives on the falling edge.
- Left slot: b=1..24 are shifted MSB-first (b=0 is the I2S delay bit). b=25..31 are ignored.
- Right slot: b=33..56 are shifted MSB-first. b=32 and b=57..63 are ignored.
- Frame end: at the last clk of b=63 the pair is complete.
- State machine:
  - IDLE: sck=0, ws=0, counters held at 0. If enable=1, go to WARMUP with the frame counter cleared and overflow cleared.
  - WARMUP: bus runs and frames are captured but discarded. At the end of frame number WARMUP_FRAMES, go to RUN. If enable=0 at any time, go to STOPPING.
  - RUN: running=1 and each completed pair is offered downstream. If enable=0, go to STOPPING.
  - STOPPING: bus continues until the end of b=63 of the current frame, then goes to IDLE. That final frame's pair is still offered if stopping was entered from RUN. Enable re-asserted during STOPPING does not abort the stop; IDLE then re-enters WARMUP on the next cycle.
- Output handshake:
  - At frame end, if out_valid=0 or out_ready=1 on the same clk: out_left/out_right load the pair and out_valid=1 on the next clk.
  - Otherwise the new pair is dropped, the held pair is unchanged, and overflow is set.
  - out_valid clears one clk after out_valid&&out_ready unless a new pair loads on that same clk.
  - Held data stays stable while out_valid=1 and out_ready=0.
- Output rate: one pair per 64·2·SCK_HALF clks (1024 clks by default, 48.8 kHz).
- Reset mid-frame: immediate return to reset values; no partial pair is emitted.

Optional Feature:
Macro I2S_CAPTURE_DROP_CNT_EN.
- Defined: adds output drop_count (16 bits). It increments on each dropped pair, saturates at 16'hFFFF, is cleared on the IDLE→WARMUP transition, and resets to 0.
- Not defined: the port and counter are absent. Only the sticky overflow flag reports drops.

Test Plan:
- Reset then enable=1 with WARMUP_FRAMES=2 and SCK_HALF=8 → sck period 16 clks, ws toggles every 512 clks, no out_valid in the first 2048 clks, first out_valid ≈1024 clks later; running=1.
- Bench mic model drives left=24'h800001 and right=24'h7FFFFE (MSB at b=1/33), out_ready=1 → out_left=24'h800001 and out_right=24'h7FFFFE on every pair.
- Hold out_ready=0 across 3 frame ends → first pair is held unchanged, overflow=1, and with I2S_CAPTURE_DROP_CNT_EN drop_count=2. Then out_ready=1 → valid drops one clk later.
- Deassert enable at b=10 of a RUN frame → sck keeps toggling through b=63, that pair is delivered, then sck=0, ws=0, running=0. Re-enable → overflow cleared and warm-up repeats.
- Assert reset at b=40 → sck, ws, out_valid and overflow are 0 immediately. After release with enable=1, warm-up restarts from frame 0.
- Pulse enable for 1 clk from IDLE → WARMUP, then STOPPING, one full frame on the bus, IDLE, no out_valid.
